// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Purpose  : Parametrised SLL/SRL/SRA/ROL/ROR barrel shifter, split into
//            STAGES register stages with a bubble-collapsing valid/ready pipe.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STAGES  = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic               busy
);

    localparam int         c_lvls   = (SHAMT_W + STAGES - 1) / STAGES;
    localparam logic [2:0] c_op_sll = 3'b000;
    localparam logic [2:0] c_op_srl = 3'b001;
    localparam logic [2:0] c_op_sra = 3'b010;
    localparam logic [2:0] c_op_rol = 3'b011;
    localparam logic [2:0] c_op_ror = 3'b100;

    logic [STAGES-1:0]  r_valid;
    logic [WIDTH-1:0]   r_data  [STAGES];
    logic [SHAMT_W-1:0] r_shamt [STAGES];
    logic [2:0]         r_op    [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];
    logic               r_zero;

    logic [STAGES-1:0]  w_adv;
    logic [STAGES-1:0]  w_take;
    logic [WIDTH-1:0]   w_src_data  [STAGES];
    logic [SHAMT_W-1:0] w_src_shamt [STAGES];
    logic [2:0]         w_src_op    [STAGES];
    logic [TAG_W-1:0]   w_src_tag   [STAGES];
    logic [WIDTH-1:0]   w_res       [STAGES];

    // One mux level: shift by 2^k. SRA keeps the MSB, which is still the
    // original sign bit because every earlier level also sign-filled.
    function automatic logic [WIDTH-1:0] f_level(input logic [WIDTH-1:0] d,
                                                 input int k,
                                                 input logic [2:0] op);
        logic [WIDTH-1:0] r;
        int n;
        n = 1 << k;
        case (op)
            c_op_sll: r = d << n;
            c_op_srl: r = d >> n;
            c_op_sra: r = $signed(d) >>> n;
            c_op_rol: r = (d << n) | (d >> (WIDTH - n));
            c_op_ror: r = (d >> n) | (d << (WIDTH - n));
            default:  r = d;
        endcase
        return r;
    endfunction

    // Stall chain, walked from the output back to the input.
    always_comb begin
        logic w_ok;
        w_ok  = out_ready;
        w_adv = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_adv[s] = r_valid[s] && w_ok;
            w_ok     = !r_valid[s] || w_adv[s];
        end
    end

    assign in_ready = !r_valid[0] || w_adv[0];

    always_comb begin
        w_take    = '0;
        w_take[0] = in_valid && in_ready;
        for (int s = 1; s < STAGES; s++) begin
            w_take[s] = w_adv[s-1];
        end
    end

    always_comb begin
        w_src_data[0]  = in_data;
        w_src_shamt[0] = in_shamt;
        w_src_op[0]    = in_op;
        w_src_tag[0]   = in_tag;
        for (int s = 1; s < STAGES; s++) begin
            w_src_data[s]  = r_data[s-1];
            w_src_shamt[s] = r_shamt[s-1];
            w_src_op[s]    = r_op[s-1];
            w_src_tag[s]   = r_tag[s-1];
        end
    end

    // Level k belongs to stage k / c_lvls; the last stage gets the remainder.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            w_res[s] = w_src_data[s];
            for (int k = 0; k < SHAMT_W; k++) begin
                if (((k / c_lvls) == s) && w_src_shamt[s][k]) begin
                    w_res[s] = f_level(w_res[s], k, w_src_op[s]);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_zero  <= 1'b1;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s]  <= '0;
                r_shamt[s] <= '0;
                r_op[s]    <= '0;
                r_tag[s]   <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_take[s]) begin
                    r_valid[s] <= 1'b1;
                    r_data[s]  <= w_res[s];
                    r_shamt[s] <= w_src_shamt[s];
                    r_op[s]    <= w_src_op[s];
                    r_tag[s]   <= w_src_tag[s];
                end else if (w_adv[s]) begin
                    r_valid[s] <= 1'b0;
                end
            end
            if (w_take[STAGES-1]) begin
                r_zero <= (w_res[STAGES-1] == '0);
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_zero  = r_zero;
    assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Purpose  : Scoreboard bench: 32-bit/2-stage instance plus 8-bit instances
//            with 1, 2 and 3 stages, checked against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    typedef struct {
        longint unsigned data;
        int              tag;
        bit              zero;
        int              edge_n;
        bit              lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [2:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_zero;
    logic        busy;

    logic        v8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic [2:0]  sh8 = '0;
    logic [2:0]  op8 = '0;
    logic [3:0]  tag8 = '0;
    logic [2:0]  r8;
    logic [2:0]  ov8;
    logic [7:0]  od8 [3];
    logic [3:0]  ot8 [3];
    logic [2:0]  oz8;
    logic [2:0]  bz8;

    exp_t q32[$];
    exp_t q8[3][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b1;
    bit   rnd_done;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_zero(out_zero), .busy(busy)
    );

    generate
        for (genvar g = 0; g < 3; g++) begin : g_w8
            pipelined_barrel_shifter #(.WIDTH(8), .STAGES(g + 1), .TAG_W(4)) dut8 (
                .clock(clock), .reset(reset),
                .in_valid(v8), .in_ready(r8[g]), .in_data(d8),
                .in_shamt(sh8), .in_op(op8), .in_tag(tag8),
                .out_valid(ov8[g]), .out_ready(1'b1), .out_data(od8[g]),
                .out_tag(ot8[g]), .out_zero(oz8[g]), .busy(bz8[g])
            );
        end
    endgenerate

    // Reference: whole-word arithmetic on a w-bit value, shift amount n < w.
    function automatic longint unsigned model(input int w, input longint unsigned d,
                                              input int n, input logic [2:0] op);
        longint unsigned m;
        longint unsigned x;
        longint unsigned r;
        m = (64'd1 << w) - 1;
        x = d & m;
        case (op)
            3'd0: r = (x << n) & m;
            3'd1: r = x >> n;
            3'd2: r = (x >> n) | ((((x >> (w - 1)) & 1) != 0) ? (m & ~(m >> n)) : 64'd0);
            3'd3: r = (n == 0) ? x : (((x << n) | (x >> (w - n))) & m);
            3'd4: r = (n == 0) ? x : (((x >> n) | (x << (w - n))) & m);
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h required %0h", nm, cyc, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: event occurred, required none", nm, cyc);
    endtask

    // Monitor / scoreboard for the 32-bit instance.
    always @(negedge clock) begin
        int   occ;
        exp_t e;
        longint unsigned r;
        if (!reset) begin
            occ = q32.size();
            check("in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
            check("busy", busy, (occ != 0) ? 1 : 0);
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    fail("unexpected_out");
                end else begin
                    e = q32.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_tag", out_tag, e.tag);
                    check("out_zero", out_zero, e.zero);
                    if (e.lat && chk_lat) check("latency", cyc - e.edge_n, 2);
                end
            end
            if (in_valid && in_ready) begin
                r = model(32, in_data, int'(in_shamt), in_op);
                q32.push_back('{r, int'(in_tag), r == 0, cyc, chk_lat});
            end
        end
    end

    // Monitor / scoreboard for the 8-bit instances.
    always @(negedge clock) begin
        exp_t e;
        longint unsigned r;
        if (!reset) begin
            for (int g = 0; g < 3; g++) begin
                if (ov8[g]) begin
                    if (q8[g].size() == 0) begin
                        fail("unexpected_out8");
                    end else begin
                        e = q8[g].pop_front();
                        check("out_data8", od8[g], e.data);
                        check("out_tag8", ot8[g], e.tag);
                        check("out_zero8", oz8[g], e.zero);
                        check("latency8", cyc - e.edge_n, g + 1);
                    end
                end
                if (v8) begin
                    check("in_ready8", r8[g], 1);
                    r = model(8, d8, int'(sh8), op8);
                    q8[g].push_back('{r, int'(tag8), r == 0, cyc, 1'b1});
                end
            end
        end
    end

    // Callers are positioned 2 time units after a rising edge.
    task automatic send(input logic [31:0] d, input logic [4:0] s,
                        input logic [2:0] op, input logic [3:0] t);
        int n;
        bit took;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = t;
        do begin
            @(negedge clock);
            took = in_ready;
            @(posedge clock);
            #2;
            n++;
        end while (!took && n < 200);
        if (!took) fail("send_timeout");
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((q32.size() != 0 || q8[0].size() != 0 || q8[1].size() != 0 ||
                q8[2].size() != 0) && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("drain_q32", q32.size(), 0);
        check("drain_q8", q8[0].size() + q8[1].size() + q8[2].size(), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        idle_cycles(1);

        // Directed beats from the bring-up list.
        send(32'h0000_0001, 5'd31, 3'b000, 4'd1);
        send(32'h8000_0000, 5'd31, 3'b010, 4'd2);
        send(32'h8000_0001, 5'd1,  3'b011, 4'd3);
        send(32'h8000_0001, 5'd1,  3'b100, 4'd4);
        send(32'h0000_00FF, 5'd8,  3'b001, 4'd5);
        send(32'hDEAD_BEEF, 5'd5,  3'b111, 4'd6);
        send(32'h1234_5678, 5'd0,  3'b010, 4'd7);
        drain();

        // Streaming with a 5-cycle output stall in the middle.
        chk_lat = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) send(32'hF000_0000, n[4:0], 3'b001, n[3:0]);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clock);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 3) == 0) idle_cycles(1);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clock);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // Random traffic at full output rate; latency is checked per beat.
        for (int n = 0; n < 80; n++) begin
            send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        drain();

        // Asynchronous reset with two beats in flight.
        send(32'h1234_5678, 5'd4, 3'b000, 4'd9);
        send(32'h8765_4321, 5'd3, 3'b001, 4'd10);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        q32.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        idle_cycles(4);
        send(32'h0000_000F, 5'd4, 3'b000, 4'd11);
        drain();

        // 8-bit sweep: every op and shift amount on random data.
        for (int op = 0; op < 8; op++) begin
            for (int s = 0; s < 8; s++) begin
                v8   = 1'b1;
                d8   = 8'($urandom);
                sh8  = s[2:0];
                op8  = op[2:0];
                tag8 = 4'($urandom_range(0, 15));
                @(posedge clock);
                #2;
            end
        end
        v8 = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter for the ALU shift path, and the successor to the fixed 32-bit combinational sll/sra chains.
- Adds logical right shift, rotate left and rotate right, configurable width and pipeline depth, a valid/ready handshake with backpressure, and a sideband tag carried through the pipe.
- Sits between operand select and the ALU result mux; the execute-stage scoreboard uses the tag to match results.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and at least 4.
- SHAMT_W, log2(WIDTH), shift-amount width; derived, never overridden.
- STAGES, 2, number of register stages, legal range 1..SHAMT_W; this is also the latency.
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  shifter can accept an input beat this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount; taken modulo WIDTH by construction
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
- in_tag  input  TAG_W  sideband tag, returned unchanged with its result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result this cycle
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of the beat in out_data
- out_zero  output  1  out_data is all zeros
- busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: every stage valid bit, out_valid, out_data, out_tag and busy go to 0; out_zero goes to 1. Reset during operation discards all in-flight beats; no partial result is ever output.
- Input transfer happens on a clock edge with in_valid && in_ready. Output transfer happens on a clock edge with out_valid && out_ready.
- Per-stage rule, bubble-collapsing:
  - Stage i advances when valid[i] is set and stage i+1 is empty or advancing.
  - The last stage advances when out_ready is high.
  - in_ready = !valid[0] || stage 0 advancing. in_ready is combinational from out_ready through the stall chain; it has no registered skid.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is one beat per cycle.
- Datapath:
  - There are SHAMT_W mux levels; level k shifts by 2^k under control of shamt[k].
  - Levels are split across stages, ceil(SHAMT_W/STAGES) per stage, with the final stage taking the remainder.
  - Each stage registers the partial data together with the shamt bits still unused, the op and the tag.
- Shift semantics:
  - SLL fills with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA fills with the original in_data[WIDTH-1].
  - ROL and ROR wrap the bits that fall off one end back into the other.
  - shamt=0 returns in_data for every op.
  - Pass-through ops ignore shamt.
- Stalls: when out_valid && !out_ready, out_data, out_tag and out_zero hold stable; nothing is lost or duplicated, and upstream stages fill their bubbles before in_ready drops.
- Simultaneous input and output transfer in the same cycle with a full pipe is legal and sustains full rate.
- out_zero is registered together with out_data.
- busy = OR of all stage valid bits.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1. Send SLL 0x0000_0001 shamt 31 -> 0x8000_0000 two cycles later. Send SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF, out_zero=0.
- Back-to-back ROL 0x8000_0001 shamt 1, then ROR 0x8000_0001 shamt 1, tags 3 then 4 -> 0x0000_0003 tag 3, then 0xC000_0000 tag 4, on consecutive cycles.
- Streaming under backpressure: stream 8 beats, SRL 0xF000_0000 with shamt 0..7, tags 0..7. Hold out_ready=0 for 5 cycles mid-stream -> all 8 results arrive in order with no loss or duplicates. Results are 0xF000_0000 >> n. in_ready=0 exactly while the pipe is full and stalled.
- Zero and pass-through: SRL 0x0000_00FF shamt 8 -> 0x0000_0000 with out_zero=1. Op 111 with 0xDEAD_BEEF shamt 5 -> 0xDEAD_BEEF.
- Asynchronous reset with 2 beats in flight: assert reset asynchronously -> out_valid=0 and busy=0 immediately, and no stale result appears after release. The first post-reset beat has latency 2.
- Parameter sweep: WIDTH=8 with STAGES 1, 2 and 3, every op and every shamt 0..7 on random data -> matches the behavioural model; latency equals STAGES.
